exe_div_seq: RTL

Multi-cycle sequencer for the RV64M divide/remainder ops (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW) issued from the execute stage. It replaces single-cycle combinational division with an iterative restoring divider. While an op is in flight it holds the execute stage via a stall line. It releases the stall in the cycle the result is valid, so execute latches DIV_RESULT into MEM_ALU_RESULT.

---
 rtl/exe_div_seq_pkg.sv | 27 ++
 rtl/exe_div_seq_if.sv | 25 ++
 rtl/exe_div_step.sv | 24 ++
 rtl/exe_div_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exe_div_seq_pkg.sv
// Shared types and constants for the execute-stage divide sequencer.
package exe_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [6:0] OP_OP         = 7'b0110011;
    localparam logic [6:0] OP_OP32       = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } div_state_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/exe_div_seq_if.sv
// Execute-stage <-> divide sequencer handshake bundle.
interface exe_div_seq_if;

    logic                     DIV_START;
    logic [1:0]               DIV_OP;
    logic                     DIV_WORD;
    logic [exe_pkg::XLEN-1:0] DIV_A;
    logic [exe_pkg::XLEN-1:0] DIV_B;
    logic                     DIV_FLUSH;
    logic                     DIV_BUSY;
    logic                     DIV_DONE;
    logic [exe_pkg::XLEN-1:0] DIV_RESULT;
    logic                     V_EXE_DIV_STALL;

    modport master (
        output DIV_START, DIV_OP, DIV_WORD, DIV_A, DIV_B, DIV_FLUSH,
        input  DIV_BUSY, DIV_DONE, DIV_RESULT, V_EXE_DIV_STALL
    );

    modport slave (
        input  DIV_START, DIV_OP, DIV_WORD, DIV_A, DIV_B, DIV_FLUSH,
        output DIV_BUSY, DIV_DONE, DIV_RESULT, V_EXE_DIV_STALL
    );

endinterface

// File: rtl/exe_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module exe_div_step
    import exe_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // rem < divisor always holds, so the shifted value fits XLEN+1 bits and
    // diff[XLEN] is a clean borrow flag.
    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        diff     = rem_sh - {1'b0, divisor};
        quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
        rem_next = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/exe_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer with execute-stage stall.
// Optional one-entry result cache enabled by EXE_DIV_RESULT_CACHE_EN.
module exe_div_seq
    import exe_pkg::*;
(
    input  logic         clk,
    input  logic         RESET_N,
    exe_div_seq_if.slave div_if
);

    div_state_t state, state_next;

    logic [1:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q;
    logic [6:0]      count_q;
    logic            qneg_q, rneg_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            cache_hit;
    logic [XLEN-1:0] cache_res;

    logic            sgn;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_min;
    logic            a_neg, b_neg, div_zero, ovf, special;
    logic [XLEN-1:0] sp_quo, sp_rem, sp_res;
    logic [XLEN-1:0] q_fix, r_fix, fix_res;
    logic [XLEN-1:0] step_rem, step_quo;

    assign accept = div_if.DIV_START & ~div_if.DIV_FLUSH;

    exe_div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Operand conditioning and special-case detection on the latched op (PREP).
    always_comb begin
        sgn      = ~op_q[0];
        a_ext    = word_q ? (sgn ? sext_word(a_q) : {32'b0, a_q[31:0]}) : a_q;
        b_ext    = word_q ? (sgn ? sext_word(b_q) : {32'b0, b_q[31:0]}) : b_q;
        a_neg    = sgn & a_ext[XLEN-1];
        b_neg    = sgn & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        a_min    = word_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = sgn & (a_ext == a_min) & (b_ext == '1);
        special  = div_zero | ovf;
        sp_quo   = div_zero ? '1 : a_ext;
        sp_rem   = div_zero ? a_ext : '0;
        sp_res   = op_q[1] ? sp_rem : sp_quo;
        if (word_q) sp_res = sext_word(sp_res);
    end

    always_comb begin
        q_fix = qneg_q ? -quo_q : quo_q;
        r_fix = rneg_q ? -rem_q : rem_q;
        if (word_q) begin
            q_fix = sext_word(q_fix);
            r_fix = sext_word(r_fix);
        end
        fix_res = op_q[1] ? r_fix : q_fix;
    end

`ifdef EXE_DIV_RESULT_CACHE_EN
    logic            c_valid;
    logic [XLEN-1:0] c_a, c_b, c_quo, c_rem;
    logic            c_sgn, c_word;

    always_comb begin
        cache_hit = c_valid & (div_if.DIV_A == c_a) & (div_if.DIV_B == c_b)
                  & (~div_if.DIV_OP[0] == c_sgn) & (div_if.DIV_WORD == c_word);
        cache_res = div_if.DIV_OP[1] ? c_rem : c_quo;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            c_valid <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_sgn   <= 1'b0;
            c_word  <= 1'b0;
            c_quo   <= '0;
            c_rem   <= '0;
        end else if (state == ST_FIX && !div_if.DIV_FLUSH) begin
            c_valid <= 1'b1;
            c_a     <= a_q;
            c_b     <= b_q;
            c_sgn   <= sgn;
            c_word  <= word_q;
            c_quo   <= q_fix;
            c_rem   <= r_fix;
        end
    end
`else
    always_comb begin
        cache_hit = 1'b0;
        cache_res = '0;
    end
`endif

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept) state_next = cache_hit ? ST_DONE : ST_PREP;
            ST_PREP: begin
                if (div_if.DIV_FLUSH) state_next = ST_IDLE;
                else if (special)     state_next = ST_DONE;
                else                  state_next = ST_ITER;
            end
            ST_ITER: begin
                if (div_if.DIV_FLUSH)     state_next = ST_IDLE;
                else if (count_q == 7'd1) state_next = ST_FIX;
            end
            ST_FIX:  state_next = div_if.DIV_FLUSH ? ST_IDLE : ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        div_if.DIV_BUSY        = (state == ST_PREP) | (state == ST_ITER) | (state == ST_FIX);
        div_if.DIV_DONE        = (state == ST_DONE);
        div_if.V_EXE_DIV_STALL = ((state == ST_IDLE) & accept) | div_if.DIV_BUSY;
        div_if.DIV_RESULT      = result_q;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q     <= '0;
            word_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            count_q  <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= div_if.DIV_OP;
                        word_q <= div_if.DIV_WORD;
                        a_q    <= div_if.DIV_A;
                        b_q    <= div_if.DIV_B;
                        if (cache_hit) result_q <= cache_res;
                    end
                end
                ST_PREP: begin
                    qneg_q  <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    rem_q   <= '0;
                    div_q   <= b_abs;
                    // Word ops run 32 steps, so the dividend is pre-aligned to the top half.
                    quo_q   <= word_q ? {a_abs[31:0], 32'b0} : a_abs;
                    count_q <= word_q ? 7'd32 : 7'd64;
                    if (special && !div_if.DIV_FLUSH) result_q <= sp_res;
                end
                ST_ITER: begin
                    rem_q   <= step_rem;
                    quo_q   <= step_quo;
                    count_q <= count_q - 7'd1;
                end
                ST_FIX: begin
                    if (!div_if.DIV_FLUSH) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule
